// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg -- shared definitions for the UART RX sequencer.
//   state_e        : binary state encoding (ST_IDLE..ST_BREAK)
//   DATA_BITS_DEF  : default data bits per frame
//   PARITY_ODD_SEL : parity sense (0 = even parity)
package uart_rx_pkg;

    localparam int DATA_BITS_DEF = 8;

    // 0 selects even parity: the parity bit makes the total count of ones even.
    localparam logic PARITY_ODD_SEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;

    // Expected parity bit for a received word reduction.
    function automatic logic parity_bit(input logic word_xor);
        return word_xor ^ PARITY_ODD_SEL;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- SYNC_STAGES-deep flop chain for an asynchronous input.
// Flops reset to 1 so an idle-high serial line is not mistaken for a start bit.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronised output
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '1;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive sequencer.
// Watches the synchronised serial line, drives count_en/half_full into the
// external bit timer, samples start/data/stop bits on its en ticks and emits
// the received word with a one-cycle data_valid or frame_err strobe.
// Optional: define UART_RX_PARITY_EN to add a parity bit between data and
// stop and a parity_err strobe output.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   rx                  : raw serial line (idle high, asynchronous)
//   en                  : mid-bit tick from the bit timer
//   count_en, half_full : bit-timer enable and interval select
//   data                : last received word
//   data_valid          : one-cycle strobe, stop bit good
//   frame_err           : one-cycle strobe, stop bit low
//   parity_err          : (parity build only) strobe with data_valid/frame_err
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 en,
    output logic                 count_en,
    output logic                 half_full,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int             CW   = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  LAST = CW'(DATA_BITS - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  count_en_q, count_en_d;
    logic                  half_full_q, half_full_d;
    logic                  dv_q, dv_d;
    logic                  fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_q, par_bad_d;
    logic                  pe_q, pe_d;
`endif

    logic rx_s;
    logic en_v;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rx),
        .q_o     (rx_s)
    );

    // A tick is only meaningful while the timer is running.
    assign en_v = en & count_en_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rx_s) state_d = ST_START;
            ST_START: if (en_v)  state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (en_v && bit_cnt_q == LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (en_v) state_d = ST_STOP;
`endif
            ST_STOP:  if (en_v) state_d = rx_s ? ST_IDLE : ST_BREAK;
            // Held-low line must return high before a new start is armed.
            ST_BREAK: if (rx_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        count_en_d  = count_en_q;
        half_full_d = half_full_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        dv_d        = 1'b0;
        fe_d        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        pe_d        = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Also scrubs stale timer controls after an illegal-state recovery.
                count_en_d  = !rx_s;
                half_full_d = 1'b0;
            end
            ST_START: begin
                if (en_v) begin
                    if (!rx_s) begin
                        half_full_d = 1'b1;
                        bit_cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d   = 1'b0;
`endif
                    end else begin
                        count_en_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (en_v) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    // Hold at the last index instead of wrapping.
                    if (bit_cnt_q != LAST) bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (en_v) par_bad_d = rx_s ^ parity_bit(^shift_q);
            end
`endif
            ST_STOP: begin
                if (en_v) begin
                    data_d      = shift_q;
                    count_en_d  = 1'b0;
                    half_full_d = 1'b0;
                    dv_d        = rx_s;
                    fe_d        = !rx_s;
`ifdef UART_RX_PARITY_EN
                    pe_d        = par_bad_q;
`endif
                end
            end
            default: begin
                count_en_d  = 1'b0;
                half_full_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_en_q  <= 1'b0;
            half_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            fe_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            pe_q        <= 1'b0;
`endif
        end else begin
            count_en_q  <= count_en_d;
            half_full_q <= half_full_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            fe_q        <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            pe_q        <= pe_d;
`endif
        end
    end

    assign count_en   = count_en_q;
    assign half_full  = half_full_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- self-checking bench for uart_rx_ctrl.
// Includes a model of the external bit timer, a frame scoreboard and a
// table of frames, plus directed sequences for false start, back-to-back
// frames and reset mid-frame. Define UART_RX_PARITY_EN to exercise parity.
module tb_uart_rx_ctrl;

    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_EN = 11;
`else
    localparam int FRAME_EN = 10;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       rx = 1'b1;
    logic       en;
    logic       count_en, half_full;
    logic [7:0] data;
    logic       data_valid, frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .en         (en),
        .count_en   (count_en),
        .half_full  (half_full),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    // Bit-timer model: cleared while count_en is low, ticks after a half
    // or full bit period.
    int   tcnt = 0;
    int   en_cnt = 0;
    logic hf_bad = 1'b0;
    logic clr_cnt = 1'b0;

    assign en = count_en && (tcnt == ((half_full ? BIT : BIT / 2) - 1));

    always @(posedge clk) begin
        if (!count_en || en) tcnt <= 0;
        else                 tcnt <= tcnt + 1;
        if (clr_cnt) begin
            en_cnt <= 0;
            hf_bad <= 1'b0;
        end else if (en) begin
            en_cnt <= en_cnt + 1;
            // First tick of a frame is the half interval, the rest are full.
            if ((en_cnt == 0) == half_full) hf_bad <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] kind;   // {data_valid, frame_err}
        logic       pe;
    } exp_t;
    exp_t sb[$];

    // Scoreboard monitor
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (data_valid || frame_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe dv=%0b fe=%0b data=%0h expected no strobe",
                         data_valid, frame_err, data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_kind", {30'd0, data_valid, frame_err}, {30'd0, e.kind});
                chk("strobe_data", {24'd0, data}, {24'd0, e.d});
                chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
`ifdef UART_RX_PARITY_EN
                chk("strobe_parity", {31'd0, parity_err}, {31'd0, e.pe});
`endif
            end
        end
        prev_strobe <= data_valid | frame_err;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ !par_ok);
`endif
        send_bit(stop);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        exp_t e;
        e.d    = d;
        e.kind = stop ? 2'b10 : 2'b01;
        e.pe   = !par_ok;
        sb.push_back(e);
    endtask

    task automatic clear_en_count();
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 8 * BIT) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout outstanding=%0d expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_count_en"}, {31'd0, count_en}, 32'd0);
        chk({name, "_half_full"}, {31'd0, half_full}, 32'd0);
        chk({name, "_data"}, {24'd0, data}, 32'd0);
        chk({name, "_strobes"}, {30'd0, data_valid, frame_err}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
    } vec_t;
    vec_t vecs[6];

    logic       seen;
    logic [7:0] saved;

    initial begin
        vecs[0] = '{8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 1'b0};
        vecs[2] = '{8'h00, 1'b1};
        vecs[3] = '{8'hFF, 1'b1};
        vecs[4] = '{8'h5A, 1'b1};
        vecs[5] = '{8'h81, 1'b1};

        // Reset asserted at 2ns, released at 8ns.
        #2 reset_n = 1'b0;
        #4 chk_reset_outputs("reset_during");
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset_after");

        // Idle line must not start the timer.
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen |= count_en;
        end
        chk("idle_count_en", {31'd0, seen}, 32'd0);

        // Table of frames
        for (int v = 0; v < 6; v++) begin
            clear_en_count();
            expect_frame(vecs[v].d, vecs[v].stop, 1'b1);
            send_frame(vecs[v].d, vecs[v].stop, 1'b1);
            if (!vecs[v].stop) begin
                // Held-low break: no new START until the line returns high.
                seen = 1'b0;
                rx = 1'b0;
                repeat (5 * BIT) begin
                    @(negedge clk);
                    seen |= count_en;
                end
                chk("break_no_restart", {31'd0, seen}, 32'd0);
            end
            rx = 1'b1;
            repeat (2 * BIT) @(negedge clk);
            wait_drain("vec_drain");
            chk("vec_data", {24'd0, data}, {24'd0, vecs[v].d});
            chk("vec_en_count", en_cnt, FRAME_EN);
            chk("vec_half_full_seq", {31'd0, hf_bad}, 32'd0);
            chk("vec_count_en_idle", {31'd0, count_en}, 32'd0);
        end

        // False start: 3-cycle low pulse, line high again at the first tick.
        clear_en_count();
        saved = data;
        seen = 1'b0;
        rx = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= count_en;
        end
        rx = 1'b1;
        repeat (2 * BIT) begin
            @(negedge clk);
            seen |= count_en;
        end
        chk("false_start_armed", {31'd0, seen}, 32'd1);
        chk("false_start_count_en", {31'd0, count_en}, 32'd0);
        chk("false_start_en_count", en_cnt, 1);
        chk("false_start_data", {24'd0, data}, {24'd0, saved});

        // Back-to-back frames with no idle gap.
        clear_en_count();
        expect_frame(8'h00, 1'b1, 1'b1);
        expect_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        wait_drain("b2b_drain");
        chk("b2b_data", {24'd0, data}, 32'h0000_00FF);
        chk("b2b_en_count", en_cnt, 2 * FRAME_EN);

        // Reset mid-frame after 4 data bits of 0xC3.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        reset_n = 1'b0;
        #1 chk_reset_outputs("midframe_reset");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk_reset_outputs("midframe_after");
        clear_en_count();
        expect_frame(8'h5A, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        wait_drain("post_reset_drain");
        chk("post_reset_data", {24'd0, data}, 32'h0000_005A);
        chk("post_reset_en_count", en_cnt, FRAME_EN);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones; a 0 parity bit violates even parity.
        expect_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        wait_drain("parity_drain");
        chk("parity_data", {24'd0, data}, 32'h0000_0007);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
